// File: rtl/fifo_mst_arb.sv
// rtl/fifo_mst_arb.sv - FT600 245-mode FIFO bus sequencer with round-robin TX/RX arbitration
module fifo_mst_arb #(
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] tc_data,
  input  logic [3:0]  tc_be,
  input  logic        tc_txe_n,
  input  logic        tc_rxf_n,
  output logic [31:0] tp_data,
  output logic        tp_dt_oe_n,
  output logic [3:0]  tp_be,
  output logic        tp_be_oe_n,
  output logic        tp_siwu_n,
  output logic        tp_wr_n,
  output logic        tp_rd_n,
  output logic        tp_oe_n,
  input  logic        tx_valid,
  input  logic [15:0] tx_data,
  input  logic [1:0]  tx_be,
  output logic        tx_ready,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  output logic [1:0]  rx_be,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_OE, S_RD, S_TURN} state_t;
  typedef enum logic {DIR_WR, DIR_RD} dir_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_t           state, state_d;
  dir_t             last_grant, last_grant_d;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_d;

  logic wr_req, rd_req;
  logic unused_upper;

  assign wr_req       = tx_valid & ~tc_txe_n;
  assign rd_req       = rx_ready & ~tc_rxf_n;
  assign rx_data      = tc_data[15:0];
  assign rx_be        = tc_be[1:0];
  assign tp_siwu_n    = 1'b1;
  assign busy         = (state != S_IDLE);
  assign unused_upper = ^{tc_data[31:16], tc_be[3:2]};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      last_grant <= DIR_RD;
      burst_cnt  <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      burst_cnt  <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    burst_cnt_d  = burst_cnt;
    tp_data      = '0;
    tp_be        = '0;
    tp_dt_oe_n   = 1'b1;
    tp_be_oe_n   = 1'b1;
    tp_wr_n      = 1'b1;
    tp_rd_n      = 1'b1;
    tp_oe_n      = 1'b1;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        // When both sides request, the direction not served last time wins.
        if (wr_req && (!rd_req || last_grant == DIR_RD)) begin
          state_d      = S_WR;
          last_grant_d = DIR_WR;
          burst_cnt_d  = '0;
        end else if (rd_req) begin
          state_d      = S_RD_OE;
          last_grant_d = DIR_RD;
          burst_cnt_d  = '0;
        end
      end
      S_WR: begin
        tp_dt_oe_n = 1'b0;
        tp_be_oe_n = 1'b0;
        tp_data    = {16'h0000, tx_data};
        tp_be      = {2'b00, tx_be};
        tp_wr_n    = ~tx_valid;
        tx_ready   = ~tc_txe_n;
        if (wr_req) burst_cnt_d = burst_cnt + CNT_W'(1);
        if (!wr_req || burst_cnt == LAST_CNT) state_d = S_TURN;
      end
      S_RD_OE: begin
        // FT600 needs one cycle of OE before it drives valid data.
        tp_oe_n = 1'b0;
        state_d = S_RD;
      end
      S_RD: begin
        tp_oe_n  = 1'b0;
        tp_rd_n  = ~rx_ready;
        rx_valid = rd_req;
        if (rd_req) burst_cnt_d = burst_cnt + CNT_W'(1);
        if (!rd_req || burst_cnt == LAST_CNT) state_d = S_TURN;
      end
      S_TURN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_mst_arb.sv
// tb/tb_fifo_mst_arb.sv - directed and randomized self-checking bench for fifo_mst_arb
module tb_fifo_mst_arb;
  localparam int MAXB = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] tc_data;
  logic [3:0]  tc_be;
  logic        tc_txe_n, tc_rxf_n;
  logic [31:0] tp_data;
  logic        tp_dt_oe_n;
  logic [3:0]  tp_be;
  logic        tp_be_oe_n, tp_siwu_n, tp_wr_n, tp_rd_n, tp_oe_n;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic [1:0]  tx_be;
  logic        tx_ready;
  logic        rx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic [1:0]  rx_be;
  logic        busy;

  fifo_mst_arb #(.MAX_BURST(MAXB), .CNT_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .tc_data(tc_data), .tc_be(tc_be),
    .tc_txe_n(tc_txe_n), .tc_rxf_n(tc_rxf_n), .tp_data(tp_data),
    .tp_dt_oe_n(tp_dt_oe_n), .tp_be(tp_be), .tp_be_oe_n(tp_be_oe_n),
    .tp_siwu_n(tp_siwu_n), .tp_wr_n(tp_wr_n), .tp_rd_n(tp_rd_n), .tp_oe_n(tp_oe_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_be(tx_be), .tx_ready(tx_ready),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_be(rx_be),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_tests, n_fail;
  logic [17:0] tx_q[$], host_q[$], tx_got[$], rx_got[$];
  bit tx_en, txe_block, rxf_block;
  bit s_busy, s_wr_n, s_rd_n, s_oe_n, s_dt_oe_n, s_tx_hs, s_rx_v, s_tx_ready;
  bit prev_oe_n, prev_dt_oe_n, prev_busy;
  int g_words, done_words;
  bit g_dir, done_dir, g_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    prev_oe_n = 1'b1; prev_dt_oe_n = 1'b1; prev_busy = 1'b0; g_words = 0; g_done = 1'b0;
  endtask

  // Source, sink and FT600 host models: queues present their head word.
  task automatic drive();
    tx_valid = tx_en && (tx_q.size() > 0);
    {tx_be, tx_data} = 18'h0;
    if (tx_q.size() > 0) {tx_be, tx_data} = tx_q[0];
    tc_txe_n = txe_block;
    tc_rxf_n = rxf_block || (host_q.size() == 0);
    tc_data = $urandom;
    tc_be = 4'($urandom);
    if (host_q.size() > 0) {tc_be[1:0], tc_data[15:0]} = host_q[0];
  endtask

  task automatic tick();
    drive();
    #3;
    s_busy = busy; s_wr_n = tp_wr_n; s_rd_n = tp_rd_n; s_oe_n = tp_oe_n;
    s_dt_oe_n = tp_dt_oe_n; s_tx_ready = tx_ready;
    s_tx_hs = tx_valid & tx_ready; s_rx_v = rx_valid;
    check("no_contention", 32'(!tp_oe_n && !tp_dt_oe_n), 0);
    check("upper_zero", {tp_data[31:16], tp_be[3:2], tp_siwu_n}, 32'h1);
    check("tx_hs_is_host_write", 32'(s_tx_hs), 32'(!tp_wr_n && !tc_txe_n));
    if (s_tx_hs) check("tx_word", {tp_be[1:0], tp_data[15:0]}, tx_q[0]);
    check("rx_valid_is_host_read", 32'(rx_valid), 32'(!tp_rd_n && !tp_oe_n && !tc_rxf_n));
    if (rx_valid) check("rx_word", {rx_be, rx_data}, host_q[0]);
    check("rd_after_oe_cycle", 32'(!tp_rd_n && !tp_oe_n && prev_oe_n), 0);
    check("turnaround_gap", 32'((!tp_oe_n && !prev_dt_oe_n) || (!tp_dt_oe_n && !prev_oe_n)), 0);
    g_done = 1'b0;
    if (s_tx_hs || s_rx_v) begin g_words++; g_dir = s_rx_v; end
    check("burst_bound", 32'(g_words <= MAXB), 1);
    if (!s_busy) begin
      if (prev_busy) begin g_done = 1'b1; done_words = g_words; done_dir = g_dir; end
      g_words = 0;
    end
    prev_oe_n = tp_oe_n; prev_dt_oe_n = tp_dt_oe_n; prev_busy = s_busy;
    @(posedge CLK);
    #2;
    if (s_tx_hs) tx_got.push_back(tx_q.pop_front());
    if (s_rx_v) rx_got.push_back(host_q.pop_front());
  endtask

  task automatic settle();
    bit done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (!s_busy) done = 1'b1;
    end
    check("settle_idle", 32'(done), 1);
  endtask

  initial begin
    bit [0:7]  e2_busy = 8'b01111101, e2_wr_n = 8'b10000110, e2_hs = 8'b01111001;
    bit [0:7]  e3_busy = 8'b01111110, e3_oe_n = 8'b10000011, e3_rxv = 8'b00111000;
    bit [0:11] e6_busy = 12'b011110111110, e6_rxv = 12'b001000011000, e6_rd_n = 12'b110111100011;
    int grants;
    bit exp_dir;
    n_tests = 0; n_fail = 0;
    clear_hist();
    RESET_N = 1'b0; tx_en = 1'b1; txe_block = 1'b0; rxf_block = 1'b0; rx_ready = 1'b0;
    for (int i = 1; i <= 64; i++) tx_q.push_back({2'b11, 16'(i)});

    // Reset state with a write request pending
    repeat (3) @(posedge CLK);
    #2; drive(); #3;
    check("reset_outputs", {busy, tx_ready, rx_valid, tp_wr_n, tp_rd_n, tp_oe_n, tp_dt_oe_n, tp_be_oe_n, tp_siwu_n}, 32'b000111111);
    tx_en = 1'b0; drive();
    RESET_N = 1'b1;
    @(posedge CLK); #2;

    // Write burst of MAX_BURST words, turnaround, re-grant
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("wr_busy_c%0d", i), 32'(s_busy), 32'(e2_busy[i]));
      check($sformatf("wr_strobe_c%0d", i), 32'(s_wr_n), 32'(e2_wr_n[i]));
      check($sformatf("wr_hs_c%0d", i), 32'(s_tx_hs), 32'(e2_hs[i]));
    end
    check("wr_count", tx_got.size(), 5);
    check("wr_last_word", 32'(tx_got[4][15:0]), 5);

    // Asynchronous reset in the middle of a write burst
    drive(); #3;
    RESET_N = 1'b0;
    #1;
    check("mid_reset_outputs", {tp_wr_n, tp_dt_oe_n, busy}, 32'b110);
    @(posedge CLK); #2;
    RESET_N = 1'b1;
    clear_hist();
    tick();
    check("post_reset_idle", 32'(s_busy), 0);
    tick();
    check("post_reset_wr", {s_busy, s_tx_hs}, 32'b11);
    check("post_reset_word", 32'(tx_got[tx_got.size()-1][15:0]), 6);
    tx_en = 1'b0;
    settle();

    // Read of three host words
    rx_ready = 1'b1;
    host_q.push_back({2'b11, 16'hA5A5});
    host_q.push_back({2'b01, 16'h5A5A});
    host_q.push_back({2'b10, 16'h1234});
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rd_busy_c%0d", i), 32'(s_busy), 32'(e3_busy[i]));
      check($sformatf("rd_oe_c%0d", i), 32'(s_oe_n), 32'(e3_oe_n[i]));
      check($sformatf("rd_valid_c%0d", i), 32'(s_rx_v), 32'(e3_rxv[i]));
    end
    check("rd_count", rx_got.size(), 3);
    check("rd_word0", rx_got[0], {2'b11, 16'hA5A5});
    check("rd_word1", rx_got[1], {2'b01, 16'h5A5A});
    check("rd_word2", rx_got[2], {2'b10, 16'h1234});
    rx_ready = 1'b0;

    // Host TX FIFO fills after two words
    tx_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("txe_busy_c%0d", i), 32'(s_busy), 32'(i != 0));
      check($sformatf("txe_hs_c%0d", i), 32'(s_tx_hs), 32'(i != 0));
    end
    txe_block = 1'b1;
    tick();
    check("txe_ready_low", {s_tx_ready, s_tx_hs, s_busy}, 32'b001);
    tick();
    check("txe_turn", {s_busy, s_dt_oe_n, s_wr_n}, 32'b111);
    tick();
    check("txe_idle", {s_busy, g_done}, 32'b01);
    check("txe_words", done_words, 2);
    txe_block = 1'b0; tx_en = 1'b0;

    // RX sink stalls one cycle mid-burst
    for (int i = 0; i < 3; i++) host_q.push_back({2'b01, 16'hB000 + 16'(i)});
    for (int i = 0; i < 12; i++) begin
      rx_ready = (i != 3);
      tick();
      check($sformatf("stall_busy_c%0d", i), 32'(s_busy), 32'(e6_busy[i]));
      check($sformatf("stall_valid_c%0d", i), 32'(s_rx_v), 32'(e6_rxv[i]));
      check($sformatf("stall_rd_n_c%0d", i), 32'(s_rd_n), 32'(e6_rd_n[i]));
    end
    check("stall_count", rx_got.size(), 6);
    for (int i = 0; i < 3; i++)
      check($sformatf("stall_word%0d", i), rx_got[3+i], {2'b01, 16'hB000 + 16'(i)});

    // Both directions requesting: alternating full bursts
    for (int i = 0; i < 40; i++) host_q.push_back(18'($urandom));
    tx_en = 1'b1; rx_ready = 1'b1;
    grants = 0; exp_dir = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (g_done) begin
        check("alt_len", done_words, MAXB);
        check("alt_dir", 32'(done_dir), 32'(exp_dir));
        exp_dir = ~exp_dir;
        grants++;
      end
    end
    check("alt_grants", 32'(grants >= 6), 1);
    tx_en = 1'b0; rx_ready = 1'b0;
    settle();

    // Randomized traffic with stalls on every side
    for (int i = 0; i < 3000; i++) begin
      tx_en = ($urandom_range(0, 3) != 0);
      txe_block = ($urandom_range(0, 4) == 0);
      rxf_block = ($urandom_range(0, 4) == 0);
      rx_ready = ($urandom_range(0, 3) != 0);
      if (tx_q.size() < 8) tx_q.push_back(18'($urandom));
      if (host_q.size() < 8) host_q.push_back(18'($urandom));
      tick();
    end
    tx_en = 1'b1; txe_block = 1'b0; rxf_block = 1'b0; rx_ready = 1'b1;
    for (int i = 0; i < 2000 && (tx_q.size() > 0 || host_q.size() > 0); i++) tick();
    check("drain_tx", tx_q.size(), 0);
    check("drain_rx", host_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
